// File: rtl/uart_frame_rx.sv
// 8N1 UART receiver that packs FRAME_BYTES accepted bytes into one wide word
// and strobes we_o once per complete frame; partial frames are flushed after an idle gap.
module uart_frame_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FRAME_BYTES  = 5,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     rx_i,
  output logic [8*FRAME_BYTES-1:0] data_o,
  output logic                     we_o,
  output logic                     frame_err_o,
  output logic                     busy_o,
  output logic [2:0]               state_o
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W   = $clog2(TO_CYC + 1);
  localparam int BC_W   = $clog2(FRAME_BYTES + 1);

  localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]  TO_M1     = TO_W'(TO_CYC - 1);
  localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(FRAME_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t                   state;
  logic                     rx_meta, rx_s;
  logic [CNT_W-1:0]         clk_cnt;
  logic [2:0]               bit_cnt;
  logic [7:0]               shreg;
  logic [BC_W-1:0]          byte_cnt;
  logic [TO_W-1:0]          idle_cnt;
  logic [8*FRAME_BYTES-1:0] frame_q;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      byte_cnt    <= '0;
      idle_cnt    <= '0;
      frame_q     <= '0;
      data_o      <= '0;
      we_o        <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      we_o        <= 1'b0;
      frame_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (byte_cnt != '0) begin
            if (idle_cnt == TO_M1) begin
              byte_cnt <= '0;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
          // A start edge on the expiry cycle still gets the byte_cnt clear above.
          if (!rx_s) begin
            state    <= START;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            idle_cnt <= '0;
          end
        end
        START: begin
          if (clk_cnt == HALF_M1) begin
            clk_cnt <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == FULL_M1) begin
            clk_cnt <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt == FULL_M1) begin
            clk_cnt <= '0;
            if (rx_s) begin
              state   <= IDLE;
              frame_q <= {frame_q[8*FRAME_BYTES-9:0], shreg};
              if (byte_cnt == LAST_BYTE) begin
                data_o   <= {frame_q[8*FRAME_BYTES-9:0], shreg};
                we_o     <= 1'b1;
                byte_cnt <= '0;
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
              end
            end else begin
              state       <= BREAK;
              frame_err_o <= 1'b1;
              byte_cnt    <= '0;
              frame_q     <= '0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o  = (state != IDLE) || (byte_cnt != '0);
  assign state_o = state;

endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk_i cycles per UART bit, even, >= 4.
REQ-002 SHALL have parameter FRAME_BYTES, default 5: bytes per assembled frame.
REQ-003 SHALL have parameter TIMEOUT_BITS, default 20: maximum inter-byte idle gap, in bit times, before a partial frame is flushed.
REQ-004 SHALL have port clk_i, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst_ni, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port rx_i, input, 1: asynchronous serial line, 8N1, idle high.
REQ-007 SHALL have port data_o, output, 8*FRAME_BYTES: last complete frame; first received byte in the MSBs.
REQ-008 SHALL have port we_o, output, 1: one-cycle strobe marking a new data_o, for direct connection to the CRC block write enable.
REQ-009 SHALL have port frame_err_o, output, 1: one-cycle strobe on a stop-bit error.
REQ-010 SHALL have port busy_o, output, 1: high while state != IDLE or a partial frame is held.

Function
REQ-011 SHALL pass rx_i through a 2-flop synchronizer (reset value 1); all decisions SHALL use the synchronized value rx_s.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK.
REQ-013 IDLE: on rx_s==0, SHALL go to START with the bit counter cleared.
REQ-014 START: at CLKS_PER_BIT/2-1 cycles, SHALL go to DATA if rx_s==0; otherwise it SHALL go to IDLE (glitch), with no strobe and no byte counted.
REQ-015 DATA: SHALL sample rx_s every CLKS_PER_BIT cycles (bit centre) and shift it into the byte register LSB-first; after 8 samples it SHALL go to STOP.
REQ-016 STOP: after CLKS_PER_BIT cycles, SHALL sample rx_s; if 1, the byte is accepted and the FSM SHALL go to IDLE.
REQ-017 STOP: if the sampled rx_s is 0, frame_err_o SHALL pulse, the partial frame and byte count SHALL be discarded, and the FSM SHALL go to BREAK.
REQ-018 BREAK: SHALL remain until rx_s==1, then go to IDLE, so a held-low line cannot retrigger START.
REQ-019 Accepted byte: SHALL execute frame_q <= {frame_q[8*FRAME_BYTES-9:0], byte} and increment byte_cnt.
REQ-020 When byte_cnt reaches FRAME_BYTES, data_o SHALL load the full frame and we_o SHALL be high for exactly that one cycle, the cycle after the stop sample; byte_cnt SHALL clear to 0 in the same cycle.
REQ-021 data_o SHALL hold its value until the next complete frame; it SHALL NOT change on partial frames or errors.
REQ-022 Timeout: in IDLE with byte_cnt>0, SHALL count idle cycles; at TIMEOUT_BITS*CLKS_PER_BIT cycles it SHALL clear byte_cnt silently.
REQ-023 The timeout counter SHALL restart at every START entry.
REQ-024 A start edge arriving in the same cycle the timeout expires SHALL clear byte_cnt first, and the new byte SHALL become byte 0.
REQ-025 Back-to-back bytes with zero idle gap, and back-to-back frames, SHALL be received without loss.
REQ-026 we_o and frame_err_o SHALL never be high in the same cycle.

Reset
REQ-027 On rst_ni low, SHALL immediately (asynchronously) apply: FSM=IDLE, counters=0, byte_cnt=0, frame_q=0, data_o=0, we_o=0, frame_err_o=0, busy_o=0, synchronizer flops=1.
REQ-028 A reset mid-byte or mid-frame SHALL discard all partial data; the first frame after reset release SHALL be assembled from bytes fully received after release.

Verification
REQ-029 Scenario: bytes 0x48,0x69,0x21,0x31,0xFD sent at CLKS_PER_BIT=16 with 1-bit gaps -> a single we_o pulse, data_o=40'h48_69_21_31_FD, frame_err_o=0 throughout.
REQ-030 Scenario: rx_i low for 4 cycles in idle -> no we_o, no frame_err_o, busy_o returns to 0; a following 5-byte frame is received correctly.
REQ-031 Scenario: second byte sent with stop bit=0 and line held low 40 cycles, then 5 good bytes "Hi!\0\0" -> exactly one frame_err_o pulse, then data_o=40'h48_69_21_00_00 with one we_o pulse.
REQ-032 Scenario: 3 bytes, idle 21 bit times, then 0x48,0x69,0x21,0x31,0xFD -> one we_o pulse only, data_o=40'h48_69_21_31_FD.
REQ-033 Scenario: rst_ni pulsed low mid-DATA of byte 3 -> all outputs 0 during reset; the next full 5-byte frame yields a correct data_o.
REQ-034 Scenario: 10 bytes back-to-back with zero gap -> two we_o pulses 50 bit times apart, with data_o matching each 5-byte group.
